press_event_queue: RTL

//  Downstream consumer of the button debouncer press pulses. Edge-detects up to
//  NUM_BUTTONS press lines and queues one event per press (button index, opt.

---
 rtl/press_event_queue.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/press_event_queue.sv
// press_event_queue
//   Edge-detects NUM_BUTTONS debounced press lines, collects rising edges into
//   per-button pending bits, and moves the lowest-index pending press into a
//   first-word-fall-through FIFO each cycle. The FIFO is drained over
//   eventValid/eventReady. A write into a full FIFO that is not popped in the
//   same cycle is dropped and sets the sticky overflow flag.
//   Optional feature macro: PEQ_TIMESTAMP_EN. When it is defined, a free-running
//   counter stamps each press and the stamp is shown on eventTime. When it is
//   not defined, eventTime is tied to 0.
//   The press lines come from a slow clock derived from 'clock', so they are
//   sampled directly without a synchronizer.
module press_event_queue #(
  parameter int NUM_BUTTONS = 4,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_BUTTONS-1:0]         press,
  input  logic                           eventReady,
  output logic                           eventValid,
  output logic [$clog2(NUM_BUTTONS)-1:0] eventId,
  output logic [TS_WIDTH-1:0]            eventTime,
  output logic [$clog2(DEPTH):0]         eventCount,
  output logic                           overflow,
  input  logic                           clearOverflow
);

  localparam int IW = $clog2(NUM_BUTTONS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_BUTTONS-1:0] r_press_prev;
  logic [NUM_BUTTONS-1:0] r_pending;
  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] w_sel;
  logic [IW-1:0]          w_sel_id;

  logic [IW-1:0]          r_mem_id [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;

  logic                   w_wr_req;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_write;
  logic                   w_drop;

  assign w_rise   = press & ~r_press_prev;
  assign w_wr_req = |r_pending;
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = (r_count != '0) & eventReady;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_write  = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  // Pick the lowest-index pending button as this cycle's FIFO write.
  always_comb begin
    w_sel    = '0;
    w_sel_id = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_sel_id = IW'(i);
      end
    end
  end

  // Edge history and pending bits. History resets high so a press held
  // through reset release is not treated as a new press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_press_prev <= '1;
      r_pending    <= '0;
    end else begin
      r_press_prev <= press;
      r_pending    <= (r_pending & ~w_sel) | w_rise;
    end
  end

  // FIFO storage. The contents need no reset because the outputs are masked
  // while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem_id[r_wr_ptr] <= w_sel_id;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The occupancy
  // counter is kept separately from the pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow. When a drop and a clear happen in the same cycle, the
  // drop wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clearOverflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign eventValid = (r_count != '0);
  assign eventId    = eventValid ? r_mem_id[r_rd_ptr] : '0;
  assign eventCount = r_count;
  assign overflow   = r_overflow;

`ifdef PEQ_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_pend_ts [NUM_BUTTONS];
  logic [TS_WIDTH-1:0] r_mem_ts  [DEPTH];
  logic [TS_WIDTH-1:0] w_sel_ts;

  // Free-running stamp counter that wraps to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + TS_WIDTH'(1);
  end

  // Latch the stamp only when the pending bit is newly set. A rise that
  // merges into an existing press keeps the original stamp.
  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_pend_ts
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_pend_ts[gi] <= '0;
      end else if (w_rise[gi] & ~(r_pending[gi] & ~w_sel[gi])) begin
        r_pend_ts[gi] <= r_ts;
      end
    end
  end

  // Route the selected button's stamp to the FIFO write port. w_sel is one-hot.
  always_comb begin
    w_sel_ts = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (w_sel[i]) w_sel_ts = r_pend_ts[i];
    end
  end

  // Timestamp storage alongside the index.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem_ts[r_wr_ptr] <= w_sel_ts;
    end
  end

  assign eventTime = eventValid ? r_mem_ts[r_rd_ptr] : '0;
`else
  assign eventTime = '0;
`endif

endmodule
